calib_accumulator: RTL and testbench
====================================

CALIB_ACCUMULATOR -- requirements
Module: calib_accumulator

Interface
REQ-001 SHALL have parameter SUM_W, default 32: width of the running sum.
REQ-002 SHALL have parameter CNT_W, default 16: width of the line and error counters.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: in_pair and in_last are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1: block accepts a pair this cycle.
REQ-007 SHALL have port in_pair, input, 16: [15:8] is the ASCII tens digit, [7:0] is the ASCII ones digit (the per-line result of the upstream day stage).
REQ-008 SHALL have port in_last, input, 1: the accepted pair is the final line.
REQ-009 SHALL have port sum_out, output, SUM_W: running binary total.
REQ-010 SHALL have port line_count, output, CNT_W: number of accepted pairs.
REQ-011 SHALL have port err_count, output, CNT_W: number of accepted pairs rejected as non-digit.
REQ-012 SHALL have port ovf, output, 1: sticky flag for sum wrap.
REQ-013 SHALL have port done, output, 1: final line has been fully processed.

Function
REQ-014 SHALL implement an FSM with states S_ACCEPT, S_CONV, S_ADD, S_BCD (macro only) and S_DONE; the state after reset is S_ACCEPT.
REQ-015 SHALL drive in_ready=1 only in S_ACCEPT; a transfer occurs when in_valid && in_ready, registering in_pair and in_last, then moving to S_CONV.
REQ-016 In S_CONV, SHALL compute value = (tens-0x30)*10 + (ones-0x30), 7 bits, range 0..99, and mark the pair invalid if either byte is outside 0x30..0x39; next state is S_ADD.
REQ-017 In S_ADD, SHALL add value to sum_out if the pair is valid, otherwise increment err_count and leave sum_out unchanged; line_count increments in both cases.
REQ-018 After S_ADD, SHALL go to S_DONE (or S_BCD when enabled) if the registered last flag is set, else return to S_ACCEPT.
REQ-019 Latency: a pair accepted at edge N SHALL be reflected in sum_out, line_count and err_count after edge N+2; throughput is 1 pair per 3 cycles.
REQ-020 SHALL compute the sum modulo 2^SUM_W; a carry out SHALL set ovf, which stays set until reset.
REQ-021 line_count and err_count SHALL saturate at all-ones.
REQ-022 S_DONE SHALL be terminal: done=1, in_ready=0, outputs held, in_valid ignored, exit only via reset.
REQ-023 While not in S_ACCEPT, a held in_valid SHALL NOT be consumed or duplicated.

Reset
REQ-024 Asserting rst low at any time, including mid-pair or mid-conversion, SHALL immediately set state=S_ACCEPT, sum_out=0, line_count=0, err_count=0, ovf=0, done=0 and in_ready=1 (once released), and discard any in-flight pair.

Configuration
REQ-025 Macro CALIB_ACC_BCD_OUT_EN defined: SHALL add output port bcd_out, width 4*ceil(SUM_W*log10(2)) (40 bits for SUM_W=32), and the S_BCD state, which runs an iterative double-dabble for SUM_W cycles before S_DONE; done rises only after bcd_out is valid; bcd_out resets to 0.
REQ-026 Macro not defined: SHALL have no bcd_out port and no S_BCD state; S_ADD goes directly to S_DONE on last.

Structure
REQ-027 Package calib_pkg SHALL hold the state enum, ASCII_ZERO=8'h30, ASCII_NINE=8'h39, and a function giving the BCD digit count from SUM_W.
REQ-028 The double-dabble SHALL be sub-module bin2bcd_seq (start/busy/done handshake), instantiated only under CALIB_ACC_BCD_OUT_EN.

Verification
REQ-029 Pairs "12","38","15","77" with last on "77" -> sum_out=142, line_count=4, err_count=0, done=1; with the macro enabled, bcd_out=...0142.
REQ-030 Pairs "29","1a","83" (last) -> sum_out=112, line_count=3, err_count=1.
REQ-031 SUM_W=8, pairs "99","99","99" (last) -> sum_out=41, ovf=1.
REQ-032 in_valid held high continuously with the same pair "55" for 9 cycles, last=0 -> exactly 3 accepts, sum_out=165, in_ready pattern 1,0,0 repeating.
REQ-033 rst low for 1 cycle during S_CONV of the second pair -> all outputs 0; next pair "07" (last) -> sum_out=7, line_count=1.
REQ-034 After done=1, drive in_valid with "99" -> sum_out and line_count unchanged, in_ready=0.

Source files
------------

// File: rtl/calib_pkg.sv
// Shared constants for the calibration accumulator: FSM state codes, ASCII digit bounds
// and BCD sizing. S_BCD exists only when CALIB_ACC_BCD_OUT_EN is defined.
package calib_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_ACCEPT = 3'd0;
  localparam state_t S_CONV   = 3'd1;
  localparam state_t S_ADD    = 3'd2;
  localparam state_t S_DONE   = 3'd3;
`ifdef CALIB_ACC_BCD_OUT_EN
  localparam state_t S_BCD    = 3'd4;
`endif

  // ceil(sum_w * log10(2)); the product is never an integer for sum_w > 0
  function automatic int unsigned bcd_digits(input int unsigned sum_w);
    return (sum_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Only built when CALIB_ACC_BCD_OUT_EN is defined.
`ifdef CALIB_ACC_BCD_OUT_EN
module bin2bcd_seq
  import calib_pkg::*;
#(
  parameter int unsigned SUM_W = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [SUM_W-1:0]                  bin,
  output logic                              busy,
  output logic                              done,
  output logic [4*bcd_digits(SUM_W)-1:0]    bcd
);

  localparam int unsigned DIGITS = bcd_digits(SUM_W);
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned IDX_W  = $clog2(SUM_W) + 1;

  logic [SUM_W-1:0] bin_q;
  logic [BCD_W-1:0] adj_c;
  logic [IDX_W-1:0] cnt;

  // add-3 correction on every digit that would reach 10 or more after the shift
  always_comb begin
    adj_c = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (adj_c[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = adj_c[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q <= '0;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        bin_q <= bin;
        bcd   <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        bcd   <= {adj_c[BCD_W-2:0], bin_q[SUM_W-1]};
        bin_q <= bin_q << 1;
        cnt   <= cnt + IDX_W'(1);
        if (cnt == IDX_W'(SUM_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/calib_accumulator.sv
// Accumulates ASCII two-digit calibration values into a binary running sum.
// CALIB_ACC_BCD_OUT_EN adds a BCD copy of the final sum (bcd_out) via bin2bcd_seq.
module calib_accumulator
  import calib_pkg::*;
#(
  parameter int unsigned SUM_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [15:0]                    in_pair,
  input  logic                           in_last,
  output logic [SUM_W-1:0]               sum_out,
  output logic [CNT_W-1:0]               line_count,
  output logic [CNT_W-1:0]               err_count,
  output logic                           ovf,
`ifdef CALIB_ACC_BCD_OUT_EN
  output logic [4*bcd_digits(SUM_W)-1:0] bcd_out,
`endif
  output logic                           done
);

  localparam int unsigned SUM_EW = SUM_W + 1;

  state_t           state;
  state_t           state_next;
  logic [15:0]      pair_q;
  logic             last_q;
  logic [6:0]       value_q;
  logic             valid_q;

  logic             accept_c;
  logic [3:0]       tens_dig_c;
  logic [3:0]       ones_dig_c;
  logic             digits_ok_c;
  logic [6:0]       value_c;
  logic [SUM_W:0]   sum_ext_c;

`ifdef CALIB_ACC_BCD_OUT_EN
  logic             bcd_start;
  logic             bcd_busy;
  logic             bcd_done;

  bin2bcd_seq #(.SUM_W(SUM_W)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (sum_out),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd_out)
  );
`endif

  assign accept_c    = in_valid && (state == S_ACCEPT);
  assign tens_dig_c  = 4'(pair_q[15:8] - ASCII_ZERO);
  assign ones_dig_c  = 4'(pair_q[7:0] - ASCII_ZERO);
  assign digits_ok_c = (pair_q[15:8] >= ASCII_ZERO) && (pair_q[15:8] <= ASCII_NINE) &&
                       (pair_q[7:0]  >= ASCII_ZERO) && (pair_q[7:0]  <= ASCII_NINE);
  assign value_c     = 7'(tens_dig_c) * 7'd10 + 7'(ones_dig_c);
  assign sum_ext_c   = {1'b0, sum_out} + SUM_EW'(value_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_ACCEPT;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_ACCEPT: if (accept_c) state_next = S_CONV;
      S_CONV:   state_next = S_ADD;
`ifdef CALIB_ACC_BCD_OUT_EN
      S_ADD:    state_next = last_q ? S_BCD : S_ACCEPT;
      S_BCD:    if (bcd_done) state_next = S_DONE;
`else
      S_ADD:    state_next = last_q ? S_DONE : S_ACCEPT;
`endif
      S_DONE:   state_next = S_DONE;
      default:  state_next = S_ACCEPT;
    endcase
  end

  // datapath and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready   <= 1'b1;
      done       <= 1'b0;
      pair_q     <= '0;
      last_q     <= 1'b0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      sum_out    <= '0;
      line_count <= '0;
      err_count  <= '0;
      ovf        <= 1'b0;
    end else begin
      in_ready <= (state_next == S_ACCEPT);
      done     <= (state_next == S_DONE);
      if (accept_c) begin
        pair_q <= in_pair;
        last_q <= in_last;
      end
      if (state == S_CONV) begin
        value_q <= value_c;
        valid_q <= digits_ok_c;
      end
      if (state == S_ADD) begin
        if (line_count != '1) line_count <= line_count + CNT_W'(1);
        if (valid_q) begin
          sum_out <= sum_ext_c[SUM_W-1:0];
          if (sum_ext_c[SUM_W]) ovf <= 1'b1;
        end else if (err_count != '1) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

`ifdef CALIB_ACC_BCD_OUT_EN
  // start one cycle after the final add so the converter latches the settled sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bcd_start <= 1'b0;
    else      bcd_start <= (state == S_ADD) && last_q && !bcd_busy;
  end
`endif

endmodule

// File: tb/tb_calib_accumulator.sv
// Directed bench for calib_accumulator: a SUM_W=32 instance and a SUM_W=8/CNT_W=2 instance.
module tb_calib_accumulator;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_last, in_ready, ovf, done;
  logic [15:0] in_pair;
  logic [31:0] sum_out;
  logic [15:0] line_count, err_count;

  logic        rst8, in_valid8, in_last8, in_ready8, ovf8, done8;
  logic [15:0] in_pair8;
  logic [7:0]  sum_out8;
  logic [1:0]  line_count8, err_count8;

`ifdef CALIB_ACC_BCD_OUT_EN
  logic [39:0] bcd_out;
  logic [11:0] bcd_out8;
`endif

  int tests = 0;
  int fails = 0;

  calib_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pair(in_pair),
    .in_last(in_last), .sum_out(sum_out), .line_count(line_count), .err_count(err_count),
    .ovf(ovf),
`ifdef CALIB_ACC_BCD_OUT_EN
    .bcd_out(bcd_out),
`endif
    .done(done)
  );

  calib_accumulator #(.SUM_W(8), .CNT_W(2)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .in_pair(in_pair8),
    .in_last(in_last8), .sum_out(sum_out8), .line_count(line_count8), .err_count(err_count8),
    .ovf(ovf8),
`ifdef CALIB_ACC_BCD_OUT_EN
    .bcd_out(bcd_out8),
`endif
    .done(done8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset(input bit s8);
    if (s8) rst8 = 1'b0; else rst = 1'b0;
    idle(1);
    if (s8) rst8 = 1'b1; else rst = 1'b1;
  endtask

  // waits (bounded) for in_ready, then presents one pair for exactly one edge
  task automatic send(input bit s8, input logic [15:0] p, input logic l);
    int n;
    n = 0;
    while (((s8 ? in_ready8 : in_ready) !== 1'b1) && n < 20) begin
      idle(1);
      n++;
    end
    check("ready_wait", 64'(n < 20), 64'd1);
    if (s8) begin in_valid8 = 1'b1; in_pair8 = p; in_last8 = l; end
    else    begin in_valid  = 1'b1; in_pair  = p; in_last  = l; end
    idle(1);
    if (s8) in_valid8 = 1'b0; else in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit s8);
    int n;
    n = 0;
    while (((s8 ? done8 : done) !== 1'b1) && n < 100) begin
      idle(1);
      n++;
    end
    check("done_wait", 64'(n < 100), 64'd1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pair = '0; in_last = 1'b0;
    rst8 = 1'b0; in_valid8 = 1'b0; in_pair8 = '0; in_last8 = 1'b0;
    idle(2);
    check("rst_sum", 64'(sum_out), 64'd0);
    check("rst_line", 64'(line_count), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst8_sum", 64'(sum_out8), 64'd0);
    rst = 1'b1; rst8 = 1'b1;
    idle(1);

    // held in_valid with "55": one accept every third cycle
    in_valid = 1'b1; in_pair = 16'h3535; in_last = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("hold_ready", 64'(in_ready), 64'((i % 3) == 0));
      idle(1);
    end
    in_valid = 1'b0;
    check("hold_sum", 64'(sum_out), 64'd165);
    check("hold_line", 64'(line_count), 64'd3);
    check("hold_ready_end", 64'(in_ready), 64'd1);

    // "12","38","15","77": latency observed on the first pair
    pulse_reset(1'b0);
    send(1'b0, 16'h3132, 1'b0);
    check("lat_n", 64'(line_count), 64'd0);
    idle(1);
    check("lat_n1", 64'(line_count), 64'd0);
    idle(1);
    check("lat_n2_line", 64'(line_count), 64'd1);
    check("lat_n2_sum", 64'(sum_out), 64'd12);
    send(1'b0, 16'h3338, 1'b0);
    send(1'b0, 16'h3135, 1'b0);
    send(1'b0, 16'h3737, 1'b1);
    wait_done(1'b0);
    check("basic_sum", 64'(sum_out), 64'd142);
    check("basic_line", 64'(line_count), 64'd4);
    check("basic_err", 64'(err_count), 64'd0);
    check("basic_ready", 64'(in_ready), 64'd0);
`ifdef CALIB_ACC_BCD_OUT_EN
    check("basic_bcd", 64'(bcd_out), 64'h142);
`endif

    // "99" offered after done is ignored
    in_valid = 1'b1; in_pair = 16'h3939; in_last = 1'b1;
    idle(5);
    check("post_done_sum", 64'(sum_out), 64'd142);
    check("post_done_line", 64'(line_count), 64'd4);
    check("post_done_ready", 64'(in_ready), 64'd0);
    check("post_done_done", 64'(done), 64'd1);
    in_valid = 1'b0;

    // "29","1a","83": one rejected pair
    pulse_reset(1'b0);
    send(1'b0, 16'h3239, 1'b0);
    send(1'b0, 16'h3161, 1'b0);
    send(1'b0, 16'h3833, 1'b1);
    wait_done(1'b0);
    check("err_sum", 64'(sum_out), 64'd112);
    check("err_line", 64'(line_count), 64'd3);
    check("err_err", 64'(err_count), 64'd1);

    // digit-range edges: "00" ok, '/' and ':' just outside the range
    pulse_reset(1'b0);
    send(1'b0, 16'h3030, 1'b0);
    send(1'b0, 16'h2F35, 1'b0);
    send(1'b0, 16'h3A35, 1'b0);
    send(1'b0, 16'h393A, 1'b0);
    send(1'b0, 16'h3939, 1'b1);
    wait_done(1'b0);
    check("edge_sum", 64'(sum_out), 64'd99);
    check("edge_line", 64'(line_count), 64'd5);
    check("edge_err", 64'(err_count), 64'd3);
    check("edge_ovf", 64'(ovf), 64'd0);

    // reset during S_CONV of the second pair
    pulse_reset(1'b0);
    send(1'b0, 16'h3132, 1'b0);
    send(1'b0, 16'h3334, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_sum", 64'(sum_out), 64'd0);
    check("midrst_line", 64'(line_count), 64'd0);
    check("midrst_err", 64'(err_count), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("midrst_ready", 64'(in_ready), 64'd1);
    send(1'b0, 16'h3037, 1'b1);
    wait_done(1'b0);
    check("midrst_after_sum", 64'(sum_out), 64'd7);
    check("midrst_after_line", 64'(line_count), 64'd1);

    // SUM_W=8 wrap: 297 mod 256 = 41
    send(1'b1, 16'h3939, 1'b0);
    send(1'b1, 16'h3939, 1'b0);
    idle(2);
    check("w8_ovf_before", 64'(ovf8), 64'd0);
    send(1'b1, 16'h3939, 1'b1);
    wait_done(1'b1);
    check("w8_sum", 64'(sum_out8), 64'd41);
    check("w8_ovf", 64'(ovf8), 64'd1);
    check("w8_line", 64'(line_count8), 64'd3);
`ifdef CALIB_ACC_BCD_OUT_EN
    check("w8_bcd", 64'(bcd_out8), 64'h041);
`endif

    // CNT_W=2: both counters stop at 3
    pulse_reset(1'b1);
    check("w8_rst_ovf", 64'(ovf8), 64'd0);
    send(1'b1, 16'h2F31, 1'b0);
    send(1'b1, 16'h2F32, 1'b0);
    send(1'b1, 16'h2F33, 1'b0);
    send(1'b1, 16'h2F34, 1'b0);
    send(1'b1, 16'h3031, 1'b1);
    wait_done(1'b1);
    check("sat_line", 64'(line_count8), 64'd3);
    check("sat_err", 64'(err_count8), 64'd3);
    check("sat_sum", 64'(sum_out8), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
